// File: rtl/sisc_exec_unit.sv
// SISC execution core: multi-cycle sequencing FSM, 32-bit ALU with flags,
// and branch-target arithmetic driving the datapath control strobes.
module sisc_exec_unit (
   input  logic        clk,
   input  logic        rst_f,
   input  logic [31:0] ir,
   input  logic [31:0] rsa,
   input  logic [31:0] rsb,
   input  logic [15:0] pc_out,
   input  logic [3:0]  srout,
   output logic [31:0] alu_result,
   output logic [3:0]  stat,
   output logic        stat_en,
   output logic [1:0]  alu_op,
   output logic [15:0] br_addr,
   output logic        br_sel,
   output logic        pc_sel,
   output logic        pc_write,
   output logic        pc_rst,
   output logic        ir_load,
   output logic        rf_we,
   output logic        wb_sel,
   output logic        rb_sel,
   output logic        halted
);
   // state     | meaning
   // START0    | reset hold, PC cleared
   // START1    | one idle cycle before the first fetch
   // FETCH     | IR loads, PC increments
   // DECODE    | opcode examined, EXECUTE strobes prepared
   // EXECUTE   | ALU evaluates / branch resolves
   // MEM       | ALU result held
   // WRITEBACK | register file written for ALU ops
   // HALT      | stopped until reset
   typedef enum logic [2:0] {
      START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
   } state_t;

   state_t state;

   logic [3:0]  op;
   logic [3:0]  mm;
   logic [15:0] imm;
   logic        is_alu;
   logic        is_br;
   logic        cond_hit;
   logic        br_taken;

   assign op       = ir[31:28];
   assign mm       = ir[27:24];
   assign imm      = ir[15:0];
   assign is_alu   = (op == 4'b0001) || (op == 4'b0010);
   assign is_br    = (op[3:2] == 2'b01);
   assign cond_hit = |(srout & mm);
   // op[1] selects the inverted (not-equal) condition
   assign br_taken = is_br && (op[1] ? !cond_hit : cond_hit);

   assign wb_sel = 1'b0;
   assign rb_sel = 1'b0;

   // Outputs are registered for the state being entered, so every output
   // is a clean function of the current state.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state    <= START0;
         pc_rst   <= 1'b1;
         ir_load  <= 1'b0;
         pc_write <= 1'b0;
         pc_sel   <= 1'b0;
         stat_en  <= 1'b0;
         rf_we    <= 1'b0;
         br_sel   <= 1'b0;
         halted   <= 1'b0;
         alu_op   <= 2'b00;
      end else begin
         pc_rst   <= 1'b0;
         ir_load  <= 1'b0;
         pc_write <= 1'b0;
         pc_sel   <= 1'b0;
         stat_en  <= 1'b0;
         rf_we    <= 1'b0;
         br_sel   <= 1'b0;
         halted   <= 1'b0;
         alu_op   <= 2'b00;
         case (state)
            START0: state <= START1;
            START1, WRITEBACK: begin
               state    <= FETCH;
               ir_load  <= 1'b1;
               pc_write <= 1'b1;
            end
            FETCH: state <= DECODE;
            DECODE: begin
               if (op == 4'b1111) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= EXECUTE;
                  if (is_alu) begin
                     alu_op  <= {1'b1, op[1]};
                     stat_en <= 1'b1;
                  end
                  if (is_br) begin
                     br_sel   <= !op[0];
                     pc_sel   <= br_taken;
                     pc_write <= br_taken;
                  end
               end
            end
            EXECUTE: begin
               state  <= MEM;
               alu_op <= alu_op;
            end
            MEM: begin
               state  <= WRITEBACK;
               alu_op <= alu_op;
               rf_we  <= alu_op[1];
            end
            HALT: begin
               state  <= HALT;
               halted <= 1'b1;
            end
            default: state <= START0;
         endcase
      end
   end

   logic [31:0] opb;
   logic [32:0] sum;
   logic [31:0] res;
   logic        c_flag;
   logic        v_flag;

   assign opb = alu_op[0] ? {{16{imm[15]}}, imm} : rsb;

   always_comb begin
      sum    = 33'd0;
      res    = 32'd0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      if (alu_op[1]) begin
         case (mm)
            4'h0: begin
               sum    = {1'b0, rsa} + {1'b0, opb};
               res    = sum[31:0];
               c_flag = sum[32];
               v_flag = (rsa[31] == opb[31]) && (sum[31] != rsa[31]);
            end
            4'h1: begin
               sum    = {1'b0, rsa} + {1'b0, ~opb} + 33'd1;
               res    = sum[31:0];
               c_flag = sum[32];
               v_flag = (rsa[31] != opb[31]) && (sum[31] != rsa[31]);
            end
            4'h2:    res = rsa & opb;
            4'h3:    res = rsa | opb;
            4'h4:    res = rsa ^ opb;
            4'h5:    res = ~rsa;
            4'h6:    res = rsa << opb[4:0];
            4'h7:    res = rsa >> opb[4:0];
            default: res = opb;
         endcase
      end
   end

   assign alu_result = res;
   assign stat       = alu_op[1] ? {c_flag, v_flag, res[31], (res == 32'd0)} : 4'b0000;
   assign br_addr    = (br_sel ? 16'h0000 : pc_out) + imm;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Directed bench for sisc_exec_unit: a per-cycle reference model checked on
// every negedge, plus literal expectations for the key instruction vectors.
module tb_sisc_exec_unit;
   logic        clk = 1'b0;
   logic        rst_f;
   logic [31:0] ir, rsa, rsb;
   logic [15:0] pc_out;
   logic [3:0]  srout;
   logic [31:0] alu_result;
   logic [3:0]  stat;
   logic        stat_en;
   logic [1:0]  alu_op;
   logic [15:0] br_addr;
   logic        br_sel, pc_sel, pc_write, pc_rst, ir_load, rf_we, wb_sel, rb_sel, halted;

   sisc_exec_unit dut (
      .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb), .pc_out(pc_out),
      .srout(srout), .alu_result(alu_result), .stat(stat), .stat_en(stat_en),
      .alu_op(alu_op), .br_addr(br_addr), .br_sel(br_sel), .pc_sel(pc_sel),
      .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load), .rf_we(rf_we),
      .wb_sel(wb_sel), .rb_sel(rb_sel), .halted(halted)
   );

   always #5 clk = ~clk;

   localparam int P_START0 = 0, P_START1 = 1, P_FETCH = 2, P_DECODE = 3,
                  P_EXEC = 4, P_MEM = 5, P_WB = 6, P_HALT = 7;

   int checks = 0;
   int errors = 0;
   int phase  = P_START0;
   bit chk_en = 1'b0;

   logic [31:0] s_result;
   logic [3:0]  s_stat;
   logic [1:0]  s_aluop;
   logic        s_staten, s_brsel, s_pcsel, s_pcw, s_rfwe, s_fetch_ld, s_fetch_pcw;
   logic [15:0] s_braddr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU from arithmetic definitions (wide signed/unsigned math).
   function automatic void model_alu(input logic [3:0] f, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic [3:0] st);
      longint ua, ub, sa, sb, t;
      logic c, v;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      case (f)
         4'h0: begin
            r = a + b;
            c = (ua + ub) > 64'sd4294967295;
            t = sa + sb;
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'h1: begin
            r = a - b;
            c = (ua >= ub);
            t = sa - sb;
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'h2:    r = a & b;
         4'h3:    r = a | b;
         4'h4:    r = a ^ b;
         4'h5:    r = ~a;
         4'h6:    r = a << b[4:0];
         4'h7:    r = a >> b[4:0];
         default: r = b;
      endcase
      st = {c, v, r[31], (r == 32'd0)};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         logic [3:0]  op, f;
         logic [31:0] b, r;
         logic [3:0]  st;
         logic        alu_instr, br_instr, taken;
         logic [31:0] e_res;
         logic [3:0]  e_stat;
         logic [1:0]  e_aluop;
         logic        e_staten, e_brsel, e_pcsel, e_pcw, e_pcrst, e_irld, e_rfwe, e_halt;
         logic [15:0] e_braddr;
         op = ir[31:28];
         f  = ir[27:24];
         b  = (op == 4'd2) ? {{16{ir[15]}}, ir[15:0]} : rsb;
         model_alu(f, rsa, b, r, st);
         alu_instr = (op == 4'd1) || (op == 4'd2);
         br_instr  = (op >= 4'd4) && (op <= 4'd7);
         taken     = ((op == 4'd4) || (op == 4'd5)) ? ((srout & f) != 4'd0)
                                                    : ((srout & f) == 4'd0);
         e_res = 0; e_stat = 0; e_aluop = 0; e_staten = 0; e_brsel = 0; e_pcsel = 0;
         e_pcw = 0; e_pcrst = 0; e_irld = 0; e_rfwe = 0; e_halt = 0;
         case (phase)
            P_START0: e_pcrst = 1'b1;
            P_FETCH: begin e_irld = 1'b1; e_pcw = 1'b1; end
            P_EXEC, P_MEM, P_WB: begin
               if (alu_instr) begin
                  e_aluop  = (op == 4'd1) ? 2'b10 : 2'b11;
                  e_res    = r;
                  e_stat   = st;
                  e_staten = (phase == P_EXEC);
                  e_rfwe   = (phase == P_WB);
               end
               if (br_instr && phase == P_EXEC) begin
                  e_brsel = (op == 4'd4) || (op == 4'd6);
                  e_pcsel = taken;
                  e_pcw   = taken;
               end
            end
            P_HALT: e_halt = 1'b1;
            default: ;
         endcase
         e_braddr = (e_brsel ? 16'h0 : pc_out) + ir[15:0];
         check("alu_result", alu_result, e_res);
         check("stat", 32'(stat), 32'(e_stat));
         check("alu_op", 32'(alu_op), 32'(e_aluop));
         check("stat_en", 32'(stat_en), 32'(e_staten));
         check("br_sel", 32'(br_sel), 32'(e_brsel));
         check("br_addr", 32'(br_addr), 32'(e_braddr));
         check("pc_sel", 32'(pc_sel), 32'(e_pcsel));
         check("pc_write", 32'(pc_write), 32'(e_pcw));
         check("pc_rst", 32'(pc_rst), 32'(e_pcrst));
         check("ir_load", 32'(ir_load), 32'(e_irld));
         check("rf_we", 32'(rf_we), 32'(e_rfwe));
         check("wb_sel", 32'(wb_sel), 32'd0);
         check("rb_sel", 32'(rb_sel), 32'd0);
         check("halted", 32'(halted), 32'(e_halt));
      end
   end

   task automatic step(input int p);
      @(posedge clk);
      #1;
      phase = p;
   endtask

   task automatic run_instr(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                            input logic [15:0] pc, input logic [3:0] sr);
      step(P_FETCH);
      s_fetch_ld  = ir_load;
      s_fetch_pcw = pc_write;
      ir = i; rsa = a; rsb = b; pc_out = pc; srout = sr;
      step(P_DECODE);
      step(P_EXEC);
      s_result = alu_result; s_stat = stat; s_aluop = alu_op; s_staten = stat_en;
      s_brsel = br_sel; s_braddr = br_addr; s_pcsel = pc_sel; s_pcw = pc_write;
      step(P_MEM);
      step(P_WB);
      s_rfwe = rf_we;
   endtask

   initial begin
      rst_f = 1'b1; ir = 0; rsa = 0; rsb = 0; pc_out = 0; srout = 0;
      step(P_START0);
      chk_en = 1'b1;
      step(P_START0);
      check("rst_pc_rst", 32'(pc_rst), 32'd1);
      rst_f = 1'b0;
      step(P_START1);
      check("start1_pc_rst", 32'(pc_rst), 32'd0);

      run_instr(32'h10312000, 32'd5, 32'd7, 16'h0004, 4'b0000);
      check("first_fetch_ir_load", 32'(s_fetch_ld), 32'd1);
      check("first_fetch_pc_write", 32'(s_fetch_pcw), 32'd1);
      check("add_result", s_result, 32'd12);
      check("add_stat", 32'(s_stat), 32'b0000);
      check("add_alu_op", 32'(s_aluop), 32'b10);
      check("add_stat_en", 32'(s_staten), 32'd1);
      check("add_rf_we", 32'(s_rfwe), 32'd1);

      run_instr(32'h11312000, 32'h10, 32'h10, 16'h0005, 4'b0000);
      check("sub_zero_result", s_result, 32'd0);
      check("sub_zero_stat", 32'(s_stat), 32'b1001);

      run_instr(32'h11312000, 32'd3, 32'd5, 16'h0006, 4'b0000);
      check("sub_borrow_result", s_result, 32'hFFFFFFFE);
      check("sub_borrow_stat", 32'(s_stat), 32'b0010);

      run_instr(32'h20110001, 32'h7FFFFFFF, 32'd0, 16'h0007, 4'b0000);
      check("imm_ovf_alu_op", 32'(s_aluop), 32'b11);
      check("imm_ovf_result", s_result, 32'h80000000);
      check("imm_ovf_stat", 32'(s_stat), 32'b0110);

      run_instr(32'h10312000, 32'hFFFFFFFF, 32'd1, 16'h0008, 4'b0000);
      check("add_carry_stat", 32'(s_stat), 32'b1001);
      run_instr(32'h16312000, 32'd1, 32'd31, 16'h0009, 4'b0000);
      check("shl_result", s_result, 32'h80000000);
      run_instr(32'h2811FFFF, 32'h1234, 32'd0, 16'h000A, 4'b0000);
      check("passb_imm_result", s_result, 32'hFFFFFFFF);
      run_instr(32'h17312000, 32'h80000000, 32'd4, 16'h000B, 4'b0000);
      run_instr(32'h12312000, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h000C, 4'b0000);
      run_instr(32'h13312000, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h000C, 4'b0000);
      run_instr(32'h14312000, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h000C, 4'b0000);
      run_instr(32'h15312000, 32'h0, 32'h0, 16'h000C, 4'b0000);
      run_instr(32'h31312000, 32'd9, 32'd9, 16'h000D, 4'b1111);
      check("nop_alu_op", 32'(s_aluop), 32'b00);

      run_instr(32'h5100FFFE, 32'd0, 32'd0, 16'h0010, 4'b0001);
      check("brr_br_sel", 32'(s_brsel), 32'd0);
      check("brr_br_addr", 32'(s_braddr), 32'h000E);
      check("brr_pc_sel", 32'(s_pcsel), 32'd1);
      check("brr_pc_write", 32'(s_pcw), 32'd1);
      run_instr(32'h5100FFFE, 32'd0, 32'd0, 16'h0010, 4'b0000);
      check("brr_nt_pc_write", 32'(s_pcw), 32'd0);
      run_instr(32'h71000020, 32'd0, 32'd0, 16'h0030, 4'b0001);
      check("bnr_nt_pc_write", 32'(s_pcw), 32'd0);
      run_instr(32'h44000100, 32'd0, 32'd0, 16'h0030, 4'b0100);
      check("bra_br_addr", 32'(s_braddr), 32'h0100);

      run_instr(32'h61000040, 32'd0, 32'd0, 16'h0020, 4'b0000);
      check("bne_br_sel", 32'(s_brsel), 32'd1);
      check("bne_br_addr", 32'(s_braddr), 32'h0040);
      check("bne_pc_write", 32'(s_pcw), 32'd1);

      // reset in the middle of an ALU instruction
      step(P_FETCH);
      ir = 32'h10312000; rsa = 32'd1; rsb = 32'd2;
      step(P_DECODE);
      step(P_EXEC);
      rst_f = 1'b1;
      step(P_START0);
      check("midrst_pc_rst", 32'(pc_rst), 32'd1);
      check("midrst_alu_op", 32'(alu_op), 32'd0);
      rst_f = 1'b0;
      step(P_START1);

      step(P_FETCH);
      ir = 32'hF0000000;
      step(P_DECODE);
      for (int k = 0; k < 8; k++) step(P_HALT);
      check("halt_held", 32'(halted), 32'd1);

      rst_f = 1'b1;
      step(P_START0);
      check("halt_reset_clears", 32'(halted), 32'd0);
      rst_f = 1'b0;
      step(P_START1);
      run_instr(32'h10312000, 32'd20, 32'd22, 16'h0001, 4'b0000);
      check("post_halt_add", s_result, 32'd42);

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sisc_exec_unit.md
# sisc_exec_unit

Execution and sequencing core of the SISC processor. It combines three functions:
- a multi-cycle control FSM;
- a 32-bit ALU with status flag generation;
- branch-target arithmetic.

It sits between the instruction register, register file, status register and program counter. It decodes the current instruction word and drives all datapath control strobes.

## Interface
Parameters: none.
- clk  in  1  system clock, rising-edge
- rst_f  in  1  synchronous, active-high reset
- ir  in  32  instruction: op=ir[31:28], mm=ir[27:24], rd=ir[23:20], rs=ir[19:16], rt=ir[15:12], imm=ir[15:0]
- rsa  in  32  register-file read A (rs)
- rsb  in  32  register-file read B
- pc_out  in  16  current PC (already incremented past the fetched instruction)
- srout  in  4  status register value {C,V,N,Z}
- alu_result  out  32  ALU result
- stat  out  4  ALU status {C,V,N,Z}
- stat_en  out  1  status register load enable
- alu_op  out  2  00 idle, 10 reg-reg, 11 reg-imm, 01 reserved (treated as idle)
- br_addr  out  16  branch target
- br_sel  out  1  1 = absolute target, 0 = relative target
- pc_sel  out  1  1 = PC loads br_addr, 0 = PC increments
- pc_write  out  1  PC load strobe
- pc_rst  out  1  PC reset
- ir_load  out  1  IR load strobe
- rf_we  out  1  register-file write enable
- wb_sel  out  1  write-back mux select; constant 0 (selects ALU)
- rb_sel  out  1  read-B address select; constant 0 (selects rt)
- halted  out  1  high in HALT

## Operation
FSM states: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Reset entry: rst_f high → START0 at the next edge. START0 is held while reset is asserted.
- Normal sequence: START0 → START1 → FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH.
- DECODE with op=1111 → HALT. HALT is left only by reset.

Opcodes:
- 0000: NOP.
- 0001: ALU reg-reg; operand B = rsb.
- 0010: ALU reg-imm; operand B = sign-extended imm.
- 0100: BRA, absolute, branch if (srout & mm) ≠ 0.
- 0101: BRR, relative, same condition.
- 0110: BNE, absolute, branch if (srout & mm) = 0.
- 0111: BNR, relative, same condition.
- 1111: HLT.
- All other opcodes execute as NOP.

ALU function (mm field) with A = rsa:
- 0 ADD
- 1 SUB (A−B)
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 SHL A by B[4:0]
- 7 SHR (logical) A by B[4:0]
- 8–F pass B

ALU behaviour:
- The ALU is combinational.
- When alu_op is idle, alu_result=0 and stat=0.

Flags:
- Z = (result == 0).
- N = result[31].
- ADD: C = carry out; V = signed overflow.
- SUB: computed as A + ~B + 1; C = carry out, so C=1 means no borrow; V = signed overflow.
- All other functions: C = V = 0.

Branch target:
- br_addr = (br_sel ? 16'h0 : pc_out) + imm, modulo 2^16.
- br_sel is driven per the branch opcode in EXECUTE, and 0 otherwise.

Outputs per state (Moore; all outputs 0 and alu_op=00 unless listed):
- START0: pc_rst=1.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- EXECUTE, ALU op: alu_op = 10 (op 1) or 11 (op 2); stat_en=1.
- EXECUTE, branch: br_sel = 1 for 0100/0110, 0 for 0101/0111. If the condition is true, also pc_sel=1 and pc_write=1.
- MEM, ALU op: alu_op held.
- WRITEBACK, ALU op: alu_op held; rf_we=1.
- HALT: halted=1.

## Timing
- Reset is synchronous. The cycle after reset asserts, all outputs equal START0 values: pc_rst=1, everything else 0. This holds regardless of the state at the time reset asserts, including mid-instruction.
- First FETCH occurs 2 cycles after reset deasserts.
- Every instruction, including branches and NOPs, takes 5 cycles from FETCH through WRITEBACK.
- A taken branch updates the PC at the EXECUTE→MEM edge. The next FETCH uses the new PC.
- stat_en is high for exactly the one EXECUTE cycle of an ALU instruction.
- rf_we is high for exactly the one WRITEBACK cycle of an ALU instruction.
- alu_result is stable from EXECUTE through WRITEBACK.
- HLT: halted rises the cycle after DECODE. No further ir_load or pc_write occurs.

## Test plan
- Reset: hold rst_f 2 cycles, then release. Required: pc_rst=1 with all other outputs 0 during reset and for one cycle after; one START1 cycle with all outputs 0; then FETCH with ir_load=1, pc_write=1.
- ADD: ir=32'h10312000, rsa=5, rsb=7. In EXECUTE: alu_op=10, stat_en=1, alu_result=12, stat=4'b0000. In WRITEBACK: rf_we=1.
- SUB to zero: ir=32'h11312000, rsa=rsb=32'h10. Required: alu_result=0, stat=4'b1001.
- Immediate overflow: ir=32'h20110001, rsa=32'h7FFFFFFF. Required: alu_op=11, alu_result=32'h80000000, stat=4'b0110.
- BRR: ir=32'h5100FFFE, pc_out=16'h0010.
  - With srout=4'b0001: br_sel=0, br_addr=16'h000E, pc_sel=1, pc_write=1.
  - With srout=4'b0000: pc_write=0 in EXECUTE.
- BNE then HLT:
  - ir=32'h61000040 with srout=0: br_sel=1, br_addr=16'h0040, pc_write=1.
  - Then ir=32'hF0000000: halted=1 persistently, with no further ir_load or pc_write until reset.
